// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction-game responder.
// Holds the lamp width, the responder state enum and the one-hot test used by the control FSM.
package reaction_pkg;

    localparam int LAMP_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESS   = 2'd2,
        RELEASE = 2'd3
    } resp_state_t;

    function automatic logic is_onehot3(input logic [LAMP_W-1:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/reaction_responder_if.sv
// Lamp/button/hit link between the game core (master) and the responder (slave).
// Plain synchronous wires, no handshake: lamps and hit flow to the responder, buttons flow back.
interface reaction_responder_if;
    import reaction_pkg::*;

    logic [LAMP_W-1:0] lamp;
    logic              hit;
    logic [LAMP_W-1:0] btn;

    modport master (output lamp, output hit, input btn);
    modport slave  (input lamp, input hit, output btn);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones, clears only on reset.
// Result visible one cycle after inc; never stalls.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/reaction_responder.sv
// Self-play driver for the three-lamp game: waits delay cycles after a lamp change, then holds the button HOLD_CYCLES.
// btn rises delay+2 cycles after the change; no backpressure. RESPONDER_MISS_CNT_EN adds a saturating miss counter.
module reaction_responder
    import reaction_pkg::*;
#(
    parameter int DELAY_W     = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DELAY_W-1:0]   delay,
    reaction_responder_if.slave  gif,
    output logic [SCORE_W-1:0]   score,
    output logic                 busy,
    output logic                 err
`ifdef RESPONDER_MISS_CNT_EN
    ,
    output logic [SCORE_W-1:0]   miss
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    resp_state_t         state, state_n;
    logic [LAMP_W-1:0]   prev_lamp, target, target_n, btn_q, btn_n;
    logic [DELAY_W-1:0]  cnt, cnt_n;
    logic [HOLD_W-1:0]   hold, hold_n;
    logic                hit_seen, hit_seen_n;
    logic                err_n;
    logic                lamp_chg;
    logic                score_inc;

    assign lamp_chg = (gif.lamp != prev_lamp);

    always_comb begin
        state_n    = state;
        target_n   = target;
        cnt_n      = cnt;
        hold_n     = hold;
        hit_seen_n = hit_seen;
        err_n      = 1'b0;
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (lamp_chg && is_onehot3(gif.lamp)) begin
                        target_n = gif.lamp;
                        cnt_n    = delay;
                        state_n  = WAIT;
                    end else if (lamp_chg && (gif.lamp != '0)) begin
                        err_n = 1'b1;
                    end
                end
                WAIT: begin
                    if (lamp_chg && (gif.lamp == '0)) begin
                        state_n = IDLE;
                    end else begin
                        // Retarget keeps the running delay so the press timing is unchanged.
                        if (lamp_chg && is_onehot3(gif.lamp)) target_n = gif.lamp;
                        if (cnt == '0) begin
                            state_n    = PRESS;
                            hold_n     = HOLD_W'(HOLD_CYCLES - 1);
                            hit_seen_n = 1'b0;
                        end else begin
                            cnt_n = cnt - DELAY_W'(1);
                        end
                    end
                end
                PRESS: begin
                    if (gif.hit) hit_seen_n = 1'b1;
                    if (hold == '0) state_n = RELEASE;
                    else            hold_n  = hold - HOLD_W'(1);
                end
                RELEASE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        btn_n = (state_n == PRESS) ? target_n : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev_lamp <= '0;
            target    <= '0;
            cnt       <= '0;
            hold      <= '0;
            hit_seen  <= 1'b0;
            btn_q     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            prev_lamp <= gif.lamp;
            target    <= target_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            hit_seen  <= hit_seen_n;
            btn_q     <= btn_n;
            busy      <= (state_n != IDLE);
            err       <= err_n;
        end
    end

    assign gif.btn = btn_q;

    // Only the first hit of each press is credited.
    assign score_inc = (state == PRESS) && gif.hit && !hit_seen;

    sat_counter #(.W(SCORE_W)) u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (score_inc),
        .count (score)
    );

`ifdef RESPONDER_MISS_CNT_EN
    logic miss_inc;

    assign miss_inc = (state == PRESS) && (state_n != PRESS) && !hit_seen && !gif.hit;

    sat_counter #(.W(SCORE_W)) u_miss (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss)
    );
`endif

endmodule

// File: tb/tb_reaction_responder.sv
// Directed plus randomized bench for reaction_responder against a cycle-timeline model of the game rules.
module tb_reaction_responder;
    import reaction_pkg::*;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] dly;
    logic [7:0] score;
    logic       busy;
    logic       err;
`ifdef RESPONDER_MISS_CNT_EN
    logic [7:0] miss;
`endif

    reaction_responder_if gif ();

    reaction_responder #(.DELAY_W(8), .HOLD_CYCLES(H), .SCORE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .delay (dly),
        .gif   (gif.slave),
        .score (score),
        .busy  (busy),
        .err   (err)
`ifdef RESPONDER_MISS_CNT_EN
        ,
        .miss  (miss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;
    int exp_miss = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic chk_miss();
`ifdef RESPONDER_MISS_CNT_EN
        chk("miss", 32'(miss), 32'(exp_miss));
`endif
    endtask

    // One full service: lamp l appears in the current cycle (k=0) with delay d.
    // btn must equal l for cycles d+2..d+1+H; busy is high for 1..d+H+2.
    task automatic serve(input logic [2:0] l, input int d, input logic [H-1:0] mask);
        bit counted = 0;
        bit pend = 0;
        bit in_win;
        int idx;
        dly = 8'(d);
        gif.lamp = l;
        for (int k = 0; k <= d + H + 3; k++) begin
            if (k > 0) tick();
            if (pend) begin
                exp_score = sat_inc(exp_score);
                pend = 0;
            end
            in_win = (k >= d + 2) && (k <= d + 1 + H);
            idx = in_win ? (k - d - 2) : 0;
            gif.hit = in_win ? mask[idx] : 1'($urandom_range(0, 1));
            if (k == d + 2) gif.lamp = 3'b000;
            chk("serve_btn", 32'(gif.btn), in_win ? 32'(l) : 32'd0);
            chk("serve_busy", 32'(busy), 32'((k >= 1) && (k <= d + H + 2)));
            chk("serve_score", 32'(score), 32'(exp_score));
            chk("serve_err", 32'(err), 32'd0);
            if (in_win && gif.hit && !counted) begin
                counted = 1;
                pend = 1;
            end
        end
        gif.hit = 1'b0;
        if (!counted) exp_miss = sat_inc(exp_miss);
        chk_miss();
    endtask

    function automatic logic [2:0] rnd_onehot();
        logic [2:0] v;
        v = 3'b001 << $urandom_range(0, 2);
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        dly = 8'd0;
        gif.lamp = 3'b000;
        gif.hit = 1'b0;
        tick();
        tick();
        chk("rst_btn", 32'(gif.btn), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk_miss();
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        tick();

        // Delay 3, hit only in the second press cycle.
        serve(3'b010, 3, 4'b0010);
        tick();
        // Delay 0, hit held through the whole press: one credit only.
        serve(3'b100, 0, 4'b1111);
        tick();

        // Multi-bit lamp change: one-cycle err, no press.
        gif.lamp = 3'b011;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            if (k == 3) gif.lamp = 3'b000;
            chk("err_pulse", 32'(err), 32'(k == 1));
            chk("err_btn", 32'(gif.btn), 32'd0);
            chk("err_busy", 32'(busy), 32'd0);
        end

        // Retarget 001 -> 100 during WAIT keeps the original timing.
        dly = 8'd5;
        gif.lamp = 3'b001;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            if (k == 2) gif.lamp = 3'b100;
            if (k == 7) gif.lamp = 3'b000;
            chk("retgt_btn", 32'(gif.btn), (k >= 7 && k <= 10) ? 32'd4 : 32'd0);
            chk("retgt_busy", 32'(busy), 32'(k >= 1 && k <= 11));
        end
        exp_miss = sat_inc(exp_miss);
        chk_miss();

        // Lamp falling to zero during WAIT aborts the service.
        gif.lamp = 3'b001;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            if (k == 2) gif.lamp = 3'b000;
            chk("abort_btn", 32'(gif.btn), 32'd0);
            chk("abort_busy", 32'(busy), 32'(k >= 1 && k <= 2));
        end
        chk_miss();

        // en dropped in the second press cycle.
        dly = 8'd1;
        gif.lamp = 3'b010;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            if (k == 4) en = 1'b0;
            chk("endrop_btn", 32'(gif.btn), (k == 3 || k == 4) ? 32'd2 : 32'd0);
            chk("endrop_busy", 32'(busy), 32'(k >= 1 && k <= 4));
            chk("endrop_score", 32'(score), 32'(exp_score));
        end
        exp_miss = sat_inc(exp_miss);
        chk_miss();
        en = 1'b1;
        tick();
        gif.lamp = 3'b000;
        tick();
        tick();

        // Randomized services.
        for (int i = 0; i < 25; i++) begin
            serve(rnd_onehot(), int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Drive the score to saturation, then one more credited press.
        while (exp_score < 255) serve(rnd_onehot(), 0, 4'b0001);
        serve(3'b001, 0, 4'b0100);
        chk("sat_score", 32'(score), 32'd255);

        // Asynchronous reset mid-press clears outputs without a clock edge.
        dly = 8'd0;
        gif.lamp = 3'b001;
        tick();
        tick();
        chk("pre_rst_btn", 32'(gif.btn), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_score = 0;
        exp_miss = 0;
        chk("arst_btn", 32'(gif.btn), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        chk_miss();
        gif.lamp = 3'b000;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
